adder_checker: RTL and testbench

ADDER_CHECKER -- requirements
Module: adder_checker

---
 rtl/adder_pkg.sv | 5 +
 rtl/sat_counter.sv | 14 +
 rtl/adder_checker.sv | 91 +++++++++
 tb/tb_adder_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and default operand width for adder_checker
package adder_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;
   localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter (clk, async rst, sync clr over inc, cnt out)
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/adder_checker.sv
// adder_checker: feeds registered operands to an adder under test and checks its sum after DUT_LAT cycles (ports: clk_i rst_i, vld_i/rdy_o/a_i/b_i stimulus, dut_a_o/dut_b_o/dut_sum_i adder side, clr_i, done_o/pass_o result, chk_cnt_o/err_cnt_o/err_flag_o status; ADDER_CHECKER_FIRST_ERR_EN adds first_a_o/first_b_o/first_sum_o)
module adder_checker
   import adder_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DUT_LAT = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             vld_i,
   output logic             rdy_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] dut_a_o,
   output logic [WIDTH-1:0] dut_b_o,
   input  logic [WIDTH-1:0] dut_sum_i,
   input  logic             clr_i,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] chk_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             err_flag_o
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  ,output logic [WIDTH-1:0] first_a_o,
   output logic [WIDTH-1:0] first_b_o,
   output logic [WIDTH-1:0] first_sum_o
`endif
);
   localparam int LW = DUT_LAT > 1 ? $clog2(DUT_LAT) : 1;
   state_t        state, nxt;
   logic [LW-1:0] wcnt;
   logic          hs, chk, match;
   assign rdy_o = state == IDLE;
   assign hs    = vld_i && rdy_o;
   assign chk   = state == CHECK;
   assign match = dut_sum_i == dut_a_o + dut_b_o;
   always_comb begin
      nxt = state;
      nxt = rdy_o          ? (vld_i ? (DUT_LAT > 0 ? WAIT : CHECK) : IDLE)
          : state == WAIT  ? (wcnt == '0 ? CHECK : WAIT)
          :                  IDLE;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state      <= IDLE;
         wcnt       <= '0;
         dut_a_o    <= '0;
         dut_b_o    <= '0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         err_flag_o <= 1'b0;
      end else begin
         state      <= nxt;
         wcnt       <= hs ? LW'(DUT_LAT > 0 ? DUT_LAT - 1 : 0)
                     : (state == WAIT && wcnt != '0) ? wcnt - 1'b1 : wcnt;
         dut_a_o    <= hs ? a_i : dut_a_o;
         dut_b_o    <= hs ? b_i : dut_b_o;
         done_o     <= chk;
         pass_o     <= chk && match;
         err_flag_o <= clr_i ? 1'b0 : err_flag_o | (chk && !match);
      end
   sat_counter #(.W(CNT_W)) u_chk_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (clr_i),
      .inc (chk),
      .cnt (chk_cnt_o)
   );
   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (clr_i),
      .inc (chk && !match),
      .cnt (err_cnt_o)
   );
`ifdef ADDER_CHECKER_FIRST_ERR_EN
   logic cap;
   assign cap = chk && !match && !err_flag_o && !clr_i;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         first_a_o   <= '0;
         first_b_o   <= '0;
         first_sum_o <= '0;
      end else begin
         first_a_o   <= clr_i ? '0 : cap ? dut_a_o   : first_a_o;
         first_b_o   <= clr_i ? '0 : cap ? dut_b_o   : first_b_o;
         first_sum_o <= clr_i ? '0 : cap ? dut_sum_i : first_sum_o;
      end
`endif
endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: scoreboard bench for adder_checker at DUT_LAT=0 (u0) and directed latency/reset checks at DUT_LAT=2 (u2)
module tb_adder_checker;
   localparam int W  = 32;
   localparam int CW = 4;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      bit           clr;
   } item_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic          rst0 = 1'b1, vld0 = 1'b0, clr0 = 1'b0;
   logic [W-1:0]  a0 = '0, b0 = '0, sum0 = '0;
   logic          rdy0, done0, pass0, ef0;
   logic [W-1:0]  da0, db0;
   logic [CW-1:0] cc0, ec0;
   logic          rst2 = 1'b1, vld2 = 1'b0, clr2 = 1'b0;
   logic [W-1:0]  a2 = '0, b2 = '0, sum2 = '0;
   logic          rdy2, done2, pass2, ef2;
   logic [W-1:0]  da2, db2;
   logic [15:0]   cc2, ec2;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
   logic [W-1:0]  fa0, fb0, fs0, fa2, fb2, fs2;
`endif
   adder_checker #(.WIDTH(W), .DUT_LAT(0), .CNT_W(CW)) u0 (
      .clk_i(clk), .rst_i(rst0), .vld_i(vld0), .rdy_o(rdy0), .a_i(a0), .b_i(b0),
      .dut_a_o(da0), .dut_b_o(db0), .dut_sum_i(sum0), .clr_i(clr0), .done_o(done0),
      .pass_o(pass0), .chk_cnt_o(cc0), .err_cnt_o(ec0), .err_flag_o(ef0)
`ifdef ADDER_CHECKER_FIRST_ERR_EN
     ,.first_a_o(fa0), .first_b_o(fb0), .first_sum_o(fs0)
`endif
   );
   adder_checker #(.WIDTH(W), .DUT_LAT(2)) u2 (
      .clk_i(clk), .rst_i(rst2), .vld_i(vld2), .rdy_o(rdy2), .a_i(a2), .b_i(b2),
      .dut_a_o(da2), .dut_b_o(db2), .dut_sum_i(sum2), .clr_i(clr2), .done_o(done2),
      .pass_o(pass2), .chk_cnt_o(cc2), .err_cnt_o(ec2), .err_flag_o(ef2)
`ifdef ADDER_CHECKER_FIRST_ERR_EN
     ,.first_a_o(fa2), .first_b_o(fb2), .first_sum_o(fs2)
`endif
   );
   int n_checks = 0, n_fail = 0;
   item_t q[$];
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   logic [CW-1:0] e_cc = '0, e_ec = '0;
   logic          e_ef = 1'b0, mp;
   logic [W-1:0]  e_fa = '0, e_fb = '0, e_fs = '0, ms;
   item_t         mit;
   always @(negedge clk)
      if (!rst0 && done0) begin
         if (q.size() == 0) check("spurious_done", 1, 0);
         else begin
            mit = q.pop_front();
            ms  = mit.a + mit.b;
            mp  = ms == mit.sum;
            if (mit.clr) begin
               e_cc = '0; e_ec = '0; e_ef = 1'b0;
               e_fa = '0; e_fb = '0; e_fs = '0;
            end else begin
               if (!mp && !e_ef) begin
                  e_fa = mit.a; e_fb = mit.b; e_fs = mit.sum;
               end
               if (e_cc != '1) e_cc++;
               if (!mp && e_ec != '1) e_ec++;
               if (!mp) e_ef = 1'b1;
            end
            check("pass", pass0, mp);
            check("rdy_at_done", rdy0, 1);
            check("chk_cnt", cc0, e_cc);
            check("err_cnt", ec0, e_ec);
            check("err_flag", ef0, e_ef);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
            check("first_a", fa0, e_fa);
            check("first_b", fb0, e_fb);
            check("first_sum", fs0, e_fs);
`endif
         end
      end
   task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s, input bit clr);
      int n = 0;
      while (!rdy0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy0) check("rdy_timeout", 0, 1);
      a0 = a; b0 = b; sum0 = s; vld0 = 1'b1;
      q.push_back('{a, b, s, clr});
      @(negedge clk);
      vld0 = 1'b0;
      clr0 = clr;
      check("done_early", done0, 0);
      check("dut_a_capture", da0, a);
      check("dut_b_capture", db0, b);
      @(negedge clk);
      clr0 = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [W-1:0] ra, rb, rs;
      @(negedge clk);
      check("rst_rdy", rdy0, 1);
      check("rst_done", done0, 0);
      check("rst_cnt", cc0, 0);
      check("rst_dut_a", da0, 0);
      check("rst_flag", ef0, 0);
      rst0 = 1'b0;
      rst2 = 1'b0;
      @(negedge clk);
      check("rdy_after_rst", rdy0, 1);
      send0(32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 0);
      send0(32'h0000_1001, 32'h0000_A00A, 32'h0000_B00B, 0);
      send0(32'h0000_0001, 32'h0000_FFFF, 32'h0001_0000, 0);
      send0(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
      send0(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
      send0(32'h0000_0002, 32'h0000_0002, 32'h0000_0005, 1);
      for (int i = 0; i < 22; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = ra + rb;
         if ($urandom_range(0, 2) == 0) rs = rs ^ (32'h1 << $urandom_range(0, 31));
         send0(ra, rb, rs, 0);
      end
      repeat (3) @(negedge clk);
      check("sb_drain", q.size(), 0);
      check("sat_chk_cnt", cc0, 15);
      check("lat2_idle_rdy", rdy2, 1);
      a2 = 32'd5; b2 = 32'd7; sum2 = 32'd12; vld2 = 1'b1;
      @(negedge clk);
      a2 = 32'd100;
      check("lat2_rdy_c1", rdy2, 0);
      check("lat2_dut_a", da2, 5);
      @(negedge clk);
      check("lat2_rdy_c2", rdy2, 0);
      check("lat2_done_c2", done2, 0);
      @(negedge clk);
      check("lat2_rdy_c3", rdy2, 0);
      check("lat2_done_c3", done2, 0);
      @(negedge clk);
      check("lat2_done", done2, 1);
      check("lat2_pass", pass2, 1);
      check("lat2_rdy_done", rdy2, 1);
      check("lat2_cnt", cc2, 1);
      check("lat2_vld_ignored", da2, 5);
      sum2 = 32'd107;
      @(negedge clk);
      check("lat2_rehs_rdy", rdy2, 0);
      check("lat2_rehs_a", da2, 100);
      vld2 = 1'b0;
      rst2 = 1'b1;
      #1;
      check("midwait_rst_rdy", rdy2, 1);
      check("midwait_rst_a", da2, 0);
      check("midwait_rst_b", db2, 0);
      check("midwait_rst_cnt", cc2, 0);
      check("midwait_rst_done", done2, 0);
      check("midwait_rst_pass", pass2, 0);
      check("midwait_rst_err", {ec2, ef2}, 0);
      @(negedge clk);
      rst2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_done_after_rst", done2, 0);
         check("rdy_after_rst2", rdy2, 1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
